multdiv_controller: RTL and testbench

MULTDIV_CONTROLLER -- requirements
Module: multdiv_controller

---
 rtl/multdiv_pkg.sv | 20 ++
 rtl/multdiv_if.sv | 28 ++
 rtl/multdiv_step_counter.sv | 23 ++
 rtl/multdiv_controller.sv | 101 ++++++++++
 tb/tb_multdiv_controller.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencing controller.
package multdiv_pkg;

    localparam int unsigned MULT_STEPS = 16;
    localparam int unsigned DIV_STEPS  = 32;
    localparam int unsigned STEP_CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Step index of the final RUN iteration for the selected operation.
    function automatic logic [STEP_CNT_W-1:0] last_step(input logic div);
        return div ? STEP_CNT_W'(DIV_STEPS - 1) : STEP_CNT_W'(MULT_STEPS - 1);
    endfunction

endpackage

// File: rtl/multdiv_if.sv
// Control/status bundle between the sequencing controller and its datapath.
interface multdiv_if;

    logic                              ctrl_MULT;
    logic                              ctrl_DIV;
    logic                              divisor_zero;
    logic                              mult_overflow;
    logic                              load_operands;
    logic                              step_en;
    logic                              is_div;
    logic [multdiv_pkg::STEP_CNT_W-1:0] step_count;
    logic                              busy;
    logic                              data_resultRDY;
    logic                              data_exception;

    modport master (
        output ctrl_MULT, ctrl_DIV, divisor_zero, mult_overflow,
        input  load_operands, step_en, is_div, step_count, busy,
               data_resultRDY, data_exception
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, divisor_zero, mult_overflow,
        output load_operands, step_en, is_div, step_count, busy,
               data_resultRDY, data_exception
    );

endinterface

// File: rtl/multdiv_step_counter.sv
// Iteration counter: synchronous clear has priority over enable.
module multdiv_step_counter
    import multdiv_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    output logic [STEP_CNT_W-1:0] count
);

    // Count completed steps; cleared whenever a new operation is accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/multdiv_controller.sv
// Sequencing controller for an iterative multiply (16 steps) / divide (32 steps).
module multdiv_controller
    import multdiv_pkg::*;
(
    input logic      clock,
    input logic      reset,
    multdiv_if.slave bus
);

    state_t                state;
    state_t                next_state;
    logic                  start;
    logic                  last;
    logic                  cnt_clear;
    logic                  cnt_enable;
    logic                  load_o;
    logic                  step_o;
    logic                  busy_o;
    logic                  rdy_o;
    logic                  is_div_q;
    logic                  exc_q;
    logic [STEP_CNT_W-1:0] count;

    multdiv_step_counter u_step_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (count)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore outputs; any start pulse restarts from LOAD.
    always_comb begin
        next_state = state;
        start      = bus.ctrl_MULT | bus.ctrl_DIV;
        last       = (count == last_step(is_div_q));
        cnt_clear  = start;
        cnt_enable = 1'b0;
        load_o     = 1'b0;
        step_o     = 1'b0;
        busy_o     = 1'b0;
        rdy_o      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_LOAD;
            end
            S_LOAD: begin
                load_o = 1'b1;
                busy_o = 1'b1;
                if (start)                             next_state = S_LOAD;
                else if (is_div_q && bus.divisor_zero) next_state = S_DONE;
                else                                   next_state = S_RUN;
            end
            S_RUN: begin
                step_o     = 1'b1;
                busy_o     = 1'b1;
                cnt_enable = 1'b1;
                if (start)     next_state = S_LOAD;
                else if (last) next_state = S_DONE;
            end
            S_DONE: begin
                rdy_o      = 1'b1;
                next_state = start ? S_LOAD : S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Operation select and exception flag; a new start clears the flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            is_div_q <= 1'b0;
            exc_q    <= 1'b0;
        end else if (start) begin
            is_div_q <= ~bus.ctrl_MULT;
            exc_q    <= 1'b0;
        end else if (state == S_LOAD && is_div_q && bus.divisor_zero) begin
            exc_q <= 1'b1;
        end else if (state == S_RUN && !is_div_q && last) begin
            exc_q <= bus.mult_overflow;
        end
    end

    assign bus.load_operands  = load_o;
    assign bus.step_en        = step_o;
    assign bus.busy           = busy_o;
    assign bus.data_resultRDY = rdy_o;
    assign bus.is_div         = is_div_q;
    assign bus.data_exception = exc_q;
    assign bus.step_count     = count;

endmodule

// File: tb/tb_multdiv_controller.sv
// Self-checking bench for multdiv_controller against a cycle-indexed reference model.
module tb_multdiv_controller;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    multdiv_if bus ();

    multdiv_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs k cycles after the accepted start edge for an
    // operation of n steps: cycle 1 load, cycles 2..n+1 step, cycle n+2 ready.
    function automatic logic [11:0] model(input int k, input int n, input logic div,
                                          input logic exc_final);
        logic       load;
        logic       step;
        logic       rdy;
        logic       exc;
        logic [5:0] cnt;
        load = (k == 1);
        step = (k >= 2) && (k <= n + 1);
        rdy  = (k == n + 2);
        exc  = (k >= n + 2) ? exc_final : 1'b0;
        if (k <= 1)          cnt = 6'd0;
        else if (k <= n + 1) cnt = 6'(k - 2);
        else                 cnt = 6'(n);
        return {load, step, load | step, rdy, div, exc, cnt};
    endfunction

    function automatic logic [11:0] observed();
        return {bus.load_operands, bus.step_en, bus.busy, bus.data_resultRDY,
                bus.is_div, bus.data_exception, bus.step_count};
    endfunction

    // Present a start pulse for one clock edge; returns at cycle 1 (+1 time unit).
    task automatic start_op(input logic m, input logic d);
        bus.ctrl_MULT = m;
        bus.ctrl_DIV  = d;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        #3;
        obs = observed();
        checks++;
        if (obs !== 12'd0) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", obs, 12'd0);
        end
        bus.ctrl_MULT = 1'b1;
        @(posedge clock);
        #1;
        obs = observed();
        checks++;
        if (obs !== 12'd0) begin
            errors++;
            $display("FAIL start_in_reset got=%b exp=%b", obs, 12'd0);
        end
        bus.ctrl_MULT = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        obs = observed();
        checks++;
        if (obs !== 12'd0) begin
            errors++;
            $display("FAIL idle_after_release got=%b exp=%b", obs, 12'd0);
        end
    endtask

    task automatic test_mult();
        logic [11:0] exp;
        logic [11:0] obs;
        logic        ovf_last;
        for (int r = 0; r < 3; r++) begin
            ovf_last = 1'b0;
            start_op(1'b1, 1'b0);
            for (int k = 1; k <= 20; k++) begin
                exp = model(k, 16, 1'b0, ovf_last);
                obs = observed();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL mult r=%0d k=%0d got=%b exp=%b", r, k, obs, exp);
                end
                bus.mult_overflow = 1'($urandom_range(0, 1));
                bus.divisor_zero  = 1'($urandom_range(0, 1));
                if (k == 17) begin
                    if (r == 0) bus.mult_overflow = 1'b1;
                    if (r == 1) bus.mult_overflow = 1'b0;
                    ovf_last = bus.mult_overflow;
                end
                @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic test_div();
        logic [11:0] exp;
        logic [11:0] obs;
        start_op(1'b0, 1'b1);
        for (int k = 1; k <= 36; k++) begin
            exp = model(k, 32, 1'b1, 1'b0);
            obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL div k=%0d got=%b exp=%b", k, obs, exp);
            end
            bus.mult_overflow = 1'($urandom_range(0, 1));
            bus.divisor_zero  = (k == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_div_zero();
        logic [11:0] exp;
        logic [11:0] obs;
        start_op(1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            exp = model(k, 0, 1'b1, 1'b1);
            obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL div_zero k=%0d got=%b exp=%b", k, obs, exp);
            end
            bus.mult_overflow = 1'($urandom_range(0, 1));
            bus.divisor_zero  = (k == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_both_starts();
        logic [11:0] exp;
        logic [11:0] obs;
        start_op(1'b1, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            exp = model(k, 16, 1'b0, 1'b0);
            obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL both_starts k=%0d got=%b exp=%b", k, obs, exp);
            end
            bus.divisor_zero  = 1'($urandom_range(0, 1));
            bus.mult_overflow = (k == 17) ? 1'b0 : 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_abort();
        logic [11:0] exp;
        logic [11:0] obs;
        start_op(1'b1, 1'b0);
        for (int k = 1; k <= 48; k++) begin
            bus.ctrl_DIV = 1'b0;
            exp = (k <= 12) ? model(k, 16, 1'b0, 1'b0) : model(k - 12, 32, 1'b1, 1'b0);
            obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort k=%0d got=%b exp=%b", k, obs, exp);
            end
            bus.mult_overflow = 1'($urandom_range(0, 1));
            bus.divisor_zero  = (k == 13) ? 1'b0 : 1'($urandom_range(0, 1));
            if (k == 12) bus.ctrl_DIV = 1'b1;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] exp;
        logic [11:0] obs;
        logic        ovf_last;
        start_op(1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            exp = model(k, 16, 1'b0, 1'b0);
            obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL pre_reset k=%0d got=%b exp=%b", k, obs, exp);
            end
            if (k < 7) begin
                @(posedge clock);
                #1;
            end
        end
        #2;
        reset = 1'b0;
        #1;
        obs = observed();
        checks++;
        if (obs !== 12'd0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", obs, 12'd0);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            if (c == 2) reset = 1'b1;
            obs = observed();
            checks++;
            if (obs !== 12'd0) begin
                errors++;
                $display("FAIL reset_hold c=%0d got=%b exp=%b", c, obs, 12'd0);
            end
        end
        ovf_last = 1'b0;
        start_op(1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            exp = model(k, 16, 1'b0, ovf_last);
            obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL post_reset k=%0d got=%b exp=%b", k, obs, exp);
            end
            bus.mult_overflow = (k == 17) ? 1'b1 : 1'($urandom_range(0, 1));
            if (k == 17) ovf_last = 1'b1;
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        reset             = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.divisor_zero  = 1'b0;
        bus.mult_overflow = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_both_starts();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
